// File: rtl/plic_apb_arb_if.sv
// APB bus bundle shared by both requesters and the interrupt-controller slave port.
// Also carries config_pkg, which supplies the platform data width.
package config_pkg;
    localparam int XLEN = 32;
endpackage

interface plic_apb_arb_if #(
    parameter int ADDR_W = 28,
    parameter int XLEN   = config_pkg::XLEN
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [XLEN-1:0]   PWDATA;
    logic [XLEN/8-1:0] PSTRB;
    logic [XLEN-1:0]   PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/plic_apb_arb.sv
// Two-requester round-robin APB arbiter in front of the PLIC slave port; grant to PREADY is 2 cycles with a zero-wait slave.
// Optional ACCESS-phase timeout with forced PSLVERR completion under APB_ARB_TIMEOUT_EN.
module plic_apb_arb #(
    parameter int ADDR_W         = 28,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN           = config_pkg::XLEN
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    plic_apb_arb_if.slave   m0,
    plic_apb_arb_if.slave   m1,
    plic_apb_arb_if.master  s,
    output logic            GntId
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q, last_d;
    logic   tmo_hit;
    logic   done;
    logic   cpl;
    logic   busy;
    logic   win;
    logic   other_req;
    logic [XLEN-1:0] rdata;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;  // "M1 went last" so the first contended grant goes to M0
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] tmo_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_q <= 8'd0;
        end else if (state_q == SETUP) begin
            tmo_q <= 8'd0;
        end else if (state_q == ACCESS && !s.PREADY) begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

    assign tmo_hit = (state_q == ACCESS) && !s.PREADY && (tmo_q == TMO_LAST);

    logic unused_ok;
    assign unused_ok = ^{m0.PENABLE, m1.PENABLE, s.PSLVERR};
`else
    assign tmo_hit = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{m0.PENABLE, m1.PENABLE, s.PSLVERR, TMO_LAST};
`endif

    assign done      = s.PREADY || tmo_hit;
    assign win       = (m0.PSEL && m1.PSEL) ? ~last_q : m1.PSEL;
    assign other_req = gnt_q ? m0.PSEL : m1.PSEL;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0.PSEL || m1.PSEL) begin
                    state_d = SETUP;
                    gnt_d   = win;
                    last_d  = win;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // The finishing requester still holds PSEL this cycle, so only the other side may win.
                if (done) begin
                    if (other_req) begin
                        state_d = SETUP;
                        gnt_d   = ~gnt_q;
                        last_d  = ~gnt_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        cpl       = (state_q == ACCESS) && done;
        rdata     = tmo_hit ? '0 : s.PRDATA;
        s.PSEL    = busy;
        s.PENABLE = (state_q == ACCESS);
        s.PWRITE  = '0;
        s.PADDR   = '0;
        s.PWDATA  = '0;
        s.PSTRB   = '0;
        if (busy) begin
            s.PWRITE = gnt_q ? m1.PWRITE : m0.PWRITE;
            s.PADDR  = gnt_q ? m1.PADDR  : m0.PADDR;
            s.PWDATA = gnt_q ? m1.PWDATA : m0.PWDATA;
            s.PSTRB  = gnt_q ? m1.PSTRB  : m0.PSTRB;
        end
        m0.PREADY  = cpl && !gnt_q;
        m1.PREADY  = cpl &&  gnt_q;
        m0.PRDATA  = (cpl && !gnt_q) ? rdata : '0;
        m1.PRDATA  = (cpl &&  gnt_q) ? rdata : '0;
        m0.PSLVERR = cpl && !gnt_q && tmo_hit;
        m1.PSLVERR = cpl &&  gnt_q && tmo_hit;
        GntId      = gnt_q;
    end

    a_gnt_psel_held: assert property (@(posedge PCLK) disable iff (!PRESETn)
        (state_q != IDLE) |-> (gnt_q ? m1.PSEL : m0.PSEL));
endmodule

// File: tb/tb_plic_apb_arb.sv
// Directed bench for plic_apb_arb: single transfers, contention alternation, wait states, async reset, optional timeout.
module tb_plic_apb_arb;
    localparam int ADDR_W = 28;
    localparam int XLEN   = 32;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int WAITS  = 2;
`else
    localparam int WAITS  = 5;
`endif

    logic PCLK = 1'b0;
    logic PRESETn = 1'b1;
    logic GntId;
    int   n_chk  = 0;
    int   n_fail = 0;

    plic_apb_arb_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) m0_if ();
    plic_apb_arb_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) m1_if ();
    plic_apb_arb_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) s_if ();

    plic_apb_arb #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4), .XLEN(XLEN)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .GntId   (GntId)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        m0_if.PSEL = 0; m0_if.PENABLE = 0; m0_if.PWRITE = 0; m0_if.PADDR = '0; m0_if.PWDATA = '0; m0_if.PSTRB = '0;
        m1_if.PSEL = 0; m1_if.PENABLE = 0; m1_if.PWRITE = 0; m1_if.PADDR = '0; m1_if.PWDATA = '0; m1_if.PSTRB = '0;
        s_if.PRDATA = '0; s_if.PREADY = 0; s_if.PSLVERR = 0;

        // reset values
        #2 PRESETn = 1'b0;
        #2;
        chk("rst_spsel",   32'(s_if.PSEL),     32'd0);
        chk("rst_spen",    32'(s_if.PENABLE),  32'd0);
        chk("rst_m0rdy",   32'(m0_if.PREADY),  32'd0);
        chk("rst_m1rdy",   32'(m1_if.PREADY),  32'd0);
        chk("rst_m0rdata", m0_if.PRDATA,       32'd0);
        chk("rst_gnt",     32'(GntId),         32'd0);
        repeat (3) @(posedge PCLK);
        #3 PRESETn = 1'b1;

        // single M0 write, zero-wait slave
        cyc();
        m0_if.PSEL = 1; m0_if.PWRITE = 1; m0_if.PADDR = 28'h0000004; m0_if.PWDATA = 32'h5; m0_if.PSTRB = 4'hf;
        s_if.PREADY = 1;
        settle();
        chk("wr_t_spsel", 32'(s_if.PSEL), 32'd0);
        cyc();
        chk("wr_setup_spsel",  32'(s_if.PSEL),    32'd1);
        chk("wr_setup_spen",   32'(s_if.PENABLE), 32'd0);
        chk("wr_setup_paddr",  32'(s_if.PADDR),   32'h4);
        chk("wr_setup_pwdata", s_if.PWDATA,       32'h5);
        chk("wr_setup_pwrite", 32'(s_if.PWRITE),  32'd1);
        chk("wr_setup_pstrb",  32'(s_if.PSTRB),   32'hf);
        chk("wr_setup_m0rdy",  32'(m0_if.PREADY), 32'd0);
        cyc();
        chk("wr_acc_spen",  32'(s_if.PENABLE), 32'd1);
        chk("wr_acc_m0rdy", 32'(m0_if.PREADY), 32'd1);
        chk("wr_acc_m1rdy", 32'(m1_if.PREADY), 32'd0);
        chk("wr_acc_gnt",   32'(GntId),        32'd0);
        cyc();
        m0_if.PSEL = 0; m0_if.PWRITE = 0;
        settle();
        chk("wr_idle_spsel", 32'(s_if.PSEL),    32'd0);
        chk("wr_idle_m0rdy", 32'(m0_if.PREADY), 32'd0);
        chk("wr_idle_paddr", 32'(s_if.PADDR),   32'd0);

        // M0 read
        cyc();
        m0_if.PSEL = 1; m0_if.PADDR = 28'h0200004; s_if.PRDATA = 32'h3;
        settle();
        chk("rd_t_spsel", 32'(s_if.PSEL), 32'd0);
        cyc();
        chk("rd_setup_spen",   32'(s_if.PENABLE), 32'd0);
        chk("rd_setup_paddr",  32'(s_if.PADDR),   32'h0200004);
        chk("rd_setup_rdata",  m0_if.PRDATA,      32'd0);
        cyc();
        chk("rd_acc_spen",   32'(s_if.PENABLE),  32'd1);
        chk("rd_acc_rdata",  m0_if.PRDATA,       32'h3);
        chk("rd_acc_slverr", 32'(m0_if.PSLVERR), 32'd0);
        chk("rd_acc_m1data", m1_if.PRDATA,       32'd0);
        cyc();
        m0_if.PSEL = 0;
        settle();
        chk("rd_idle_spsel", 32'(s_if.PSEL), 32'd0);

        // contention from a fresh reset: strict alternation
        PRESETn = 1'b0;
        #3 PRESETn = 1'b1;
        repeat (10) @(posedge PCLK);
        #1;
        m0_if.PSEL = 1; m0_if.PADDR = 28'h10;
        m1_if.PSEL = 1; m1_if.PADDR = 28'h20;
        s_if.PREADY = 1; s_if.PRDATA = 32'h0;
        settle();
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 7) m0_if.PSEL = 0;
            settle();
            chk($sformatf("cont%0d_setup_gnt", k), 32'(GntId), 32'(k % 2));
            chk($sformatf("cont%0d_setup_paddr", k), 32'(s_if.PADDR), (k % 2 == 0) ? 32'h10 : 32'h20);
            chk($sformatf("cont%0d_setup_rdy", k), 32'({m1_if.PREADY, m0_if.PREADY}), 32'd0);
            cyc();
            chk($sformatf("cont%0d_acc_rdy", k), 32'({m1_if.PREADY, m0_if.PREADY}), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        cyc();
        m1_if.PSEL = 0;
        settle();
        chk("cont_end_spsel", 32'(s_if.PSEL), 32'd0);
        chk("cont_end_gnt",   32'(GntId),     32'd1);

        // slave wait states
        cyc();
        m0_if.PSEL = 1; m0_if.PWRITE = 1; m0_if.PADDR = 28'h123; m0_if.PWDATA = 32'hA5A5;
        s_if.PREADY = 0;
        settle();
        cyc();
        chk("ws_setup_gnt", 32'(GntId), 32'd0);
        for (int i = 0; i < WAITS; i++) begin
            cyc();
            chk($sformatf("ws%0d_m0rdy", i),  32'(m0_if.PREADY),  32'd0);
            chk($sformatf("ws%0d_spen", i),   32'(s_if.PENABLE),  32'd1);
            chk($sformatf("ws%0d_paddr", i),  32'(s_if.PADDR),    32'h123);
            chk($sformatf("ws%0d_pwdata", i), s_if.PWDATA,        32'hA5A5);
        end
        cyc();
        s_if.PREADY = 1;
        settle();
        chk("ws_done_m0rdy",  32'(m0_if.PREADY),  32'd1);
        chk("ws_done_slverr", 32'(m0_if.PSLVERR), 32'd0);
        cyc();
        m0_if.PSEL = 0; m0_if.PWRITE = 0;
        settle();
        chk("ws_idle_spsel", 32'(s_if.PSEL), 32'd0);

        // asynchronous reset in ACCESS, then M0 wins the next contention
        cyc();
        m1_if.PSEL = 1; m1_if.PADDR = 28'h20;
        s_if.PREADY = 0;
        settle();
        cyc();
        chk("ar_setup_gnt", 32'(GntId), 32'd1);
        cyc();
        chk("ar_acc_spen", 32'(s_if.PENABLE), 32'd1);
        #1 PRESETn = 1'b0;
        #1;
        chk("ar_spsel",  32'(s_if.PSEL),    32'd0);
        chk("ar_spen",   32'(s_if.PENABLE), 32'd0);
        chk("ar_m1rdy",  32'(m1_if.PREADY), 32'd0);
        chk("ar_gnt",    32'(GntId),        32'd0);
        #1 PRESETn = 1'b1;
        m0_if.PSEL = 1; m0_if.PADDR = 28'h10;
        cyc();
        chk("ar_post_gnt",   32'(GntId),        32'd0);
        chk("ar_post_paddr", 32'(s_if.PADDR),   32'h10);
        s_if.PREADY = 1;
        cyc();
        chk("ar_post_m0rdy", 32'(m0_if.PREADY), 32'd1);
        cyc();
        m0_if.PSEL = 0;
        settle();
        chk("ar_next_gnt", 32'(GntId), 32'd1);
        cyc();
        chk("ar_next_m1rdy", 32'(m1_if.PREADY), 32'd1);
        cyc();
        m1_if.PSEL = 0;
        settle();

`ifdef APB_ARB_TIMEOUT_EN
        // stuck slave: forced error completion on the 4th ACCESS cycle
        cyc();
        m0_if.PSEL = 1; m0_if.PADDR = 28'h40;
        s_if.PREADY = 0; s_if.PRDATA = 32'h77;
        settle();
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 0) m1_if.PSEL = 1;
            settle();
            chk($sformatf("to%0d_m0rdy", i), 32'(m0_if.PREADY), 32'd0);
        end
        cyc();
        chk("to_m0rdy",   32'(m0_if.PREADY),  32'd1);
        chk("to_slverr",  32'(m0_if.PSLVERR), 32'd1);
        chk("to_rdata",   m0_if.PRDATA,       32'd0);
        cyc();
        m0_if.PSEL = 0;
        settle();
        chk("to_next_gnt",  32'(GntId),        32'd1);
        chk("to_next_spen", 32'(s_if.PENABLE), 32'd0);
        s_if.PREADY = 1;
        cyc();
        chk("to_m1rdy",   32'(m1_if.PREADY),  32'd1);
        chk("to_m1err",   32'(m1_if.PSLVERR), 32'd0);
        chk("to_m1rdata", m1_if.PRDATA,       32'h77);
        cyc();
        m1_if.PSEL = 0;
        settle();
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
